// File: rtl/bonus_pkg.sv
// rtl/bonus_pkg.sv - shared types and score constants for the bonus-ship controller
package bonus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ARMED,
    FLYING
  } bonus_state_t;

  localparam int SCORE_W_DEFAULT = 10;

  // Award per hit, indexed by the 2-bit count of missiles fired so far
  localparam int unsigned BONUS_SCORE_TABLE [4] = '{50, 100, 150, 300};

endpackage

// File: rtl/bonus_spawn_timer.sv
// rtl/bonus_spawn_timer.sv - counts frame ticks and pulses done on the tick that reaches LIMIT
module bonus_spawn_timer #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic done
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;
  logic          atLimit;

  assign atLimit = (count == CW'(LIMIT - 1));
  assign done    = enable & tick & atLimit;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && tick) begin
      count <= atLimit ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/bonus_ship_controller.sv
// rtl/bonus_ship_controller.sv - bonus-ship spawn scheduler and missile hit detector
// Define BONUS_SCORE_ROT_EN to rotate the award through BONUS_SCORE_TABLE by shots fired.
module bonus_ship_controller
  import bonus_pkg::*;
#(
  parameter int SPAWN_FRAMES  = 600,
  parameter int ALIVE_TIMEOUT = 4,
  parameter int SCORE_W       = SCORE_W_DEFAULT,
  parameter int FIXED_SCORE   = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               standBy,
  input  logic               gameEnded,
  input  logic               playerShot,
  input  logic               bonus_ship_alive,
  input  logic               bonus_ship_DR,
  input  logic               playerMissile_DR,
  output logic               rise,
  output logic               bonusFireCollision,
  output logic               scoreValid,
  output logic [SCORE_W-1:0] scoreAdd
);

  bonus_state_t       state;
  logic               playGame;
  logic               hitLatch;
  logic               hitPx;
  logic               spawnDone;
  logic               timeoutDone;
  logic [SCORE_W-1:0] awardValue;

  assign playGame = ~(standBy | gameEnded);
  assign hitPx    = (state == FLYING) & bonus_ship_DR & playerMissile_DR
                    & bonus_ship_alive & ~hitLatch;

  // Entry into WAIT counts as frame 0, so the spawn fires SPAWN_FRAMES-1 ticks later
  bonus_spawn_timer #(
    .LIMIT(SPAWN_FRAMES - 1)
  ) uSpawnTimer (
    .clk   (clk),
    .reset (reset),
    .clear (state != WAIT),
    .enable(playGame),
    .tick  (startOfFrame),
    .done  (spawnDone)
  );

  bonus_spawn_timer #(
    .LIMIT(ALIVE_TIMEOUT)
  ) uAliveTimer (
    .clk   (clk),
    .reset (reset),
    .clear (state != ARMED),
    .enable(playGame & ~bonus_ship_alive),
    .tick  (startOfFrame),
    .done  (timeoutDone)
  );

`ifdef BONUS_SCORE_ROT_EN
  logic [1:0] shotCnt;

  always_ff @(posedge clk) begin
    if (reset || (!playGame && state != IDLE)) begin
      shotCnt <= 2'd0;
    end else if (playerShot) begin
      shotCnt <= shotCnt + 2'd1;
    end
  end

  assign awardValue = SCORE_W'(BONUS_SCORE_TABLE[shotCnt]);
`else
  logic unusedPlayerShot;

  assign unusedPlayerShot = playerShot;
  assign awardValue       = SCORE_W'(FIXED_SCORE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      hitLatch           <= 1'b0;
      rise               <= 1'b0;
      bonusFireCollision <= 1'b0;
      scoreValid         <= 1'b0;
      scoreAdd           <= '0;
    end else begin
      rise               <= 1'b0;
      bonusFireCollision <= 1'b0;
      scoreValid         <= 1'b0;

      if (!playGame) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:   if (startOfFrame) state <= WAIT;
          WAIT: begin
            if (spawnDone) begin
              state <= ARMED;
              rise  <= 1'b1;
            end
          end
          ARMED: begin
            if (bonus_ship_alive) state <= FLYING;
            else if (timeoutDone) state <= WAIT;
          end
          FLYING: if (!bonus_ship_alive) state <= WAIT;
          default: state <= IDLE;
        endcase
      end

      // A hit on a frame boundary still latches; the clear only belongs to the frame that ended
      if (hitPx && playGame) begin
        bonusFireCollision <= 1'b1;
        scoreValid         <= 1'b1;
        scoreAdd           <= awardValue;
        hitLatch           <= 1'b1;
      end else if (startOfFrame) begin
        hitLatch <= 1'b0;
      end
    end
  end

endmodule
